// File: rtl/dm_arbiter.sv
// Round-robin arbiter that shares the single-ported dm_4k data memory between
// the CPU data port (requester 0) and the DMA/debug port (requester 1).
module dm_arbiter #(
   parameter int LOCK_MAX = 8
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [11:2] addr0,
   input  logic [11:2] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic        lock0,
   input  logic        lock1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        lock_err,
   output logic [11:2] mem_addr,
   output logic [31:0] mem_din,
   output logic        mem_we,
   input  logic [31:0] mem_dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

   state_t      state_q, state_d;
   logic        prio_q, prio_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        lock_err_q, lock_err_d;
   logic        gnt0_raw, gnt1_raw;

   // A locked state shuts the other requester out entirely, even if the owner idles.
   always_comb begin
      gnt0_raw = 1'b0;
      gnt1_raw = 1'b0;
      unique case (state_q)
         IDLE: begin
            gnt0_raw = req0 & (~req1 | ~prio_q);
            gnt1_raw = req1 & (~req0 |  prio_q);
         end
         LOCK0:   gnt0_raw = req0;
         LOCK1:   gnt1_raw = req1;
         default: ;
      endcase
   end

   assign gnt0 = gnt0_raw & clr_n;
   assign gnt1 = gnt1_raw & clr_n;

   assign mem_addr = gnt1 ? addr1  : addr0;
   assign mem_din  = gnt1 ? wdata1 : wdata0;
   assign mem_we   = (gnt0 & we0) | (gnt1 & we1);

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      lock_cnt_d = lock_cnt_q;
      ack0_d     = gnt0;
      ack1_d     = gnt1;
      rdata0_d   = gnt0 ? mem_dout : rdata0_q;
      rdata1_d   = gnt1 ? mem_dout : rdata1_q;
      lock_err_d = 1'b0;

      if (gnt0) begin
         prio_d = 1'b1;
      end else if (gnt1) begin
         prio_d = 1'b0;
      end

      // Forced release wins over everything else in a locked state.
      unique case (state_q)
         IDLE: begin
            if (gnt0 && lock0) begin
               state_d    = LOCK0;
               lock_cnt_d = 8'd1;
            end else if (gnt1 && lock1) begin
               state_d    = LOCK1;
               lock_cnt_d = 8'd1;
            end
         end
         LOCK0: begin
            if (lock_cnt_q == LOCK_LIMIT) begin
               state_d    = IDLE;
               prio_d     = 1'b1;
               lock_err_d = 1'b1;
               lock_cnt_d = 8'd0;
            end else if (gnt0 && !lock0) begin
               state_d    = IDLE;
               lock_cnt_d = 8'd0;
            end else begin
               lock_cnt_d = lock_cnt_q + 8'd1;
            end
         end
         LOCK1: begin
            if (lock_cnt_q == LOCK_LIMIT) begin
               state_d    = IDLE;
               prio_d     = 1'b0;
               lock_err_d = 1'b1;
               lock_cnt_d = 8'd0;
            end else if (gnt1 && !lock1) begin
               state_d    = IDLE;
               lock_cnt_d = 8'd0;
            end else begin
               lock_cnt_d = lock_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d    = IDLE;
            lock_cnt_d = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         lock_cnt_q <= 8'd0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata0_q   <= 32'd0;
         rdata1_q   <= 32'd0;
         lock_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         lock_cnt_q <= lock_cnt_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
         lock_err_q <= lock_err_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign lock_err = lock_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a transaction-level model predicts grants and
// memory traffic, queues expected acks, and a separate monitor checks them.
module tb_dm_arbiter;

   localparam int LOCK_MAX = 4;
   localparam logic [9:0] A004 = 10'd1;
   localparam logic [9:0] A010 = 10'd4;
   localparam logic [9:0] A020 = 10'd8;

   logic        clk;
   logic        clr_n;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [11:2] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, ack0, ack1, lock_err, mem_we;
   logic [31:0] rdata0, rdata1, mem_din, mem_dout;
   logic [11:2] mem_addr;

   logic [31:0] env_mem  [0:1023];
   logic [31:0] gold_mem [0:1023];

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          failures = 0;
   int          m_owner = -1;
   int          m_age = 0;
   logic        m_prio = 1'b0;
   logic        exp_lock_err = 1'b0;
   logic        m_gnt0 = 1'b0;
   logic        m_gnt1 = 1'b0;
   logic [31:0] exp_rd [2];
   logic        pend0 = 1'b0;
   logic        pend1 = 1'b0;
   logic [31:0] old020;

   dm_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .clr_n(clr_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .lock0(lock0), .lock1(lock1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1), .lock_err(lock_err),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_dout(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for dm_4k: combinational read, write at the rising edge.
   assign mem_dout = env_mem[mem_addr];
   always @(posedge clk) if (mem_we) env_mem[mem_addr] <= mem_din;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model, evaluated mid-cycle once inputs are stable.
   always @(negedge clk) begin
      int          win;
      logic        lk, wexp;
      logic [9:0]  a;
      exp_t        e;
      if (!clr_n) begin
         checkOutput("gnt0_in_reset", 32'(gnt0), 32'd0);
         checkOutput("gnt1_in_reset", 32'(gnt1), 32'd0);
         checkOutput("mem_we_in_reset", 32'(mem_we), 32'd0);
         m_owner = -1; m_age = 0; m_prio = 1'b0; exp_lock_err = 1'b0;
         m_gnt0 = 1'b0; m_gnt1 = 1'b0;
         sb_q.delete();
      end else begin
         checkOutput("lock_err", 32'(lock_err), 32'(exp_lock_err));
         if (m_owner == 0)      win = req0 ? 0 : -1;
         else if (m_owner == 1) win = req1 ? 1 : -1;
         else if (req0 && req1) win = m_prio ? 1 : 0;
         else if (req0)         win = 0;
         else if (req1)         win = 1;
         else                   win = -1;
         wexp = (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
         checkOutput("gnt0", 32'(gnt0), 32'(win == 0));
         checkOutput("gnt1", 32'(gnt1), 32'(win == 1));
         checkOutput("mem_we", 32'(mem_we), 32'(wexp));
         checkOutput("mem_addr", 32'(mem_addr), 32'((win == 1) ? addr1 : addr0));
         checkOutput("mem_din", mem_din, (win == 1) ? wdata1 : wdata0);
         m_gnt0 = (win == 0);
         m_gnt1 = (win == 1);
         if (win >= 0) begin
            a = (win == 0) ? addr0 : addr1;
            e.port = win;
            e.data = gold_mem[a];
            sb_q.push_back(e);
            if (wexp) gold_mem[a] = (win == 0) ? wdata0 : wdata1;
            m_prio = (win == 0);
         end
         exp_lock_err = 1'b0;
         if (m_owner < 0) begin
            lk = (win == 0) ? lock0 : lock1;
            if (win >= 0 && lk) begin
               m_owner = win;
               m_age = 1;
            end
         end else begin
            lk = (m_owner == 0) ? lock0 : lock1;
            if (m_age == LOCK_MAX) begin
               m_prio = (m_owner == 0);
               m_owner = -1;
               exp_lock_err = 1'b1;
            end else if (win == m_owner && !lk) begin
               m_owner = -1;
            end else begin
               m_age++;
            end
         end
      end
   end

   // Monitor: pops one expected response per observed acknowledge.
   initial begin
      exp_t e;
      exp_rd[0] = 32'd0;
      exp_rd[1] = 32'd0;
      forever begin
         @(posedge clk);
         #2;
         if (!clr_n) begin
            checkOutput("ack0_in_reset", 32'(ack0), 32'd0);
            checkOutput("ack1_in_reset", 32'(ack1), 32'd0);
            exp_rd[0] = 32'd0;
            exp_rd[1] = 32'd0;
         end else if (ack0 && ack1) begin
            checkOutput("ack_both", 32'(ack0 & ack1), 32'd0);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
         end else if (ack0 || ack1) begin
            if (sb_q.size() == 0) begin
               checkOutput("ack_unexpected", 32'(ack0 | ack1), 32'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("ack_port", 32'(ack1), 32'(e.port));
               exp_rd[e.port] = e.data;
            end
         end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("ack_missing", 32'(ack0 | ack1), 32'd1);
         end
         if (clr_n) begin
            checkOutput("rdata0", rdata0, exp_rd[0]);
            checkOutput("rdata1", rdata1, exp_rd[1]);
         end
      end
   end

   task automatic drive(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                        input logic l0, input logic r1, input logic w1, input logic [9:0] a1,
                        input logic [31:0] d1, input logic l1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
      @(posedge clk);
      #1;
   endtask

   // Randomised requester behaviour that honours the hold-until-granted rule.
   task automatic applyStimulus();
      if (!(pend0 && !m_gnt0)) begin
         req0   = ($urandom_range(0, 3) != 0);
         we0    = $urandom_range(0, 1) == 1;
         addr0  = 10'($urandom_range(0, 15));
         wdata0 = $urandom;
         lock0  = (m_owner == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
         pend0  = req0;
      end
      if (!(pend1 && !m_gnt1)) begin
         req1   = ($urandom_range(0, 3) != 0);
         we1    = $urandom_range(0, 1) == 1;
         addr1  = 10'($urandom_range(0, 15));
         wdata1 = $urandom;
         lock1  = (m_owner == 1) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
         pend1  = req1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         env_mem[i]  = 32'(i) * 32'h9E3779B9;
         gold_mem[i] = 32'(i) * 32'h9E3779B9;
      end
      env_mem[A010]  = 32'h11111111;
      gold_mem[A010] = 32'h11111111;

      clr_n = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = A004; wdata0 = 32'hFFFFFFFF; lock0 = 1'b1;
      req1 = 1'b1; we1 = 1'b1; addr1 = A020; wdata1 = 32'hFFFFFFFF; lock1 = 1'b1;
      #1;
      checkOutput("reset_gnt0", 32'(gnt0), 32'd0);
      checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset_ack0", 32'(ack0), 32'd0);
      checkOutput("reset_lock_err", 32'(lock_err), 32'd0);
      checkOutput("reset_rdata1", rdata1, 32'd0);
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      repeat (2) @(posedge clk);
      #3 clr_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed: write then cross-port read");
      drive(1'b1, 1'b1, A004, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, A020, 32'd0, 1'b0);
      checkOutput("dir_ack0", 32'(ack0), 32'd1);
      drive(1'b0, 1'b0, A004, 32'd0, 1'b0, 1'b1, 1'b0, A004, 32'd0, 1'b0);
      checkOutput("dir_rdata1", rdata1, 32'hDEADBEEF);

      $display("[TB] directed: write returns old word");
      old020 = 32'd8 * 32'h9E3779B9;
      drive(1'b1, 1'b1, A020, 32'h00000005, 1'b0, 1'b0, 1'b0, A004, 32'd0, 1'b0);
      checkOutput("dir_old_word", rdata0, old020);

      $display("[TB] directed: both requesting");
      repeat (4) drive(1'b1, 1'b0, A004, 32'd0, 1'b0, 1'b1, 1'b1, A020, 32'h0000_0077, 1'b0);

      $display("[TB] directed: requester 1 locked sequence");
      repeat (3) drive(1'b1, 1'b0, A004, 32'd0, 1'b0, 1'b1, 1'b0, A020, 32'd0, 1'b1);
      drive(1'b1, 1'b0, A004, 32'd0, 1'b0, 1'b1, 1'b0, A020, 32'd0, 1'b0);
      drive(1'b1, 1'b0, A004, 32'd0, 1'b0, 1'b0, 1'b0, A020, 32'd0, 1'b0);

      $display("[TB] directed: reset during lock");
      drive(1'b1, 1'b0, A004, 32'd0, 1'b1, 1'b0, 1'b0, A020, 32'd0, 1'b0);
      req0 = 1'b1; we0 = 1'b1; addr0 = A010; wdata0 = 32'hBADBAD00; lock0 = 1'b1;
      #2 clr_n = 1'b0;
      #1;
      checkOutput("midrst_gnt0", 32'(gnt0), 32'd0);
      checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("midrst_ack0", 32'(ack0), 32'd0);
      checkOutput("midrst_rdata0", rdata0, 32'd0);
      req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0;
      @(posedge clk);
      #3 clr_n = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, A004, 32'd0, 1'b0, 1'b1, 1'b0, A010, 32'd0, 1'b0);
      checkOutput("midrst_mem_kept", rdata1, 32'h11111111);

      $display("[TB] random phase");
      repeat (800) applyStimulus();
      repeat (LOCK_MAX + 3) drive(1'b0, 1'b0, A004, 32'd0, 1'b0, 1'b0, 1'b0, A004, 32'd0, 1'b0);
      checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
